// File: rtl/ddr3_ui_responder_if.sv
// MIG-style application (app_*) interface bundle for the DDR3 UI responder.
// The master drives commands and write data. The slave (the responder) drives
// the ready signals, read data and status.
interface ddr3_ui_responder_if #(
  parameter int ADDR_WIDTH = 29,
  parameter int DATA_WIDTH = 128
);
  logic [ADDR_WIDTH-1:0]   app_addr;
  logic [2:0]              app_cmd;
  logic                    app_en;
  logic                    app_rdy;
  logic [DATA_WIDTH-1:0]   app_wdf_data;
  logic [DATA_WIDTH/8-1:0] app_wdf_mask;
  logic                    app_wdf_wren;
  logic                    app_wdf_end;
  logic                    app_wdf_rdy;
  logic [DATA_WIDTH-1:0]   app_rd_data;
  logic                    app_rd_data_valid;
  logic                    app_rd_data_end;
  logic                    init_calib_complete;
  logic                    proto_err;

  modport master (
    output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           init_calib_complete, proto_err
  );

  modport slave (
    input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
    output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
           init_calib_complete, proto_err
  );
endinterface

// File: rtl/ddr3_ui_responder.sv
// DDR3 MIG user-interface responder: command queue, write-data FIFO, on-chip
// RAM and a fixed-latency read pipe. It stands in for the MIG core.
// Optional build macro DDR3_UI_RANDOM_STALL_EN adds LFSR-driven random
// deassertion of app_rdy / app_wdf_rdy.
module ddr3_ui_responder #(
  parameter int ADDR_WIDTH     = 29,
  parameter int DATA_WIDTH     = 128,
  parameter int MEM_DEPTH_LOG2 = 10,
  parameter int CMDQ_DEPTH     = 8,
  parameter int WDF_DEPTH      = 8,
  parameter int READ_LATENCY   = 4,
  parameter int CALIB_CYCLES   = 16
) (
  input logic      clk,
  input logic      rst_n,
  ddr3_ui_responder_if.slave ui
);
  localparam int BYTES     = DATA_WIDTH / 8;
  localparam int MEM_DEPTH = 1 << MEM_DEPTH_LOG2;
  localparam int CQ_AW     = $clog2(CMDQ_DEPTH);
  localparam int WQ_AW     = $clog2(WDF_DEPTH);
  localparam int CAL_W     = $clog2(CALIB_CYCLES + 1);
  localparam int ENTRY_W   = 1 + MEM_DEPTH_LOG2;

  logic                      calib;
  logic [CAL_W-1:0]          calib_cnt;
  logic [ENTRY_W-1:0]        cmdq [CMDQ_DEPTH];
  logic [CQ_AW:0]            cq_wr, cq_rd;
  logic [DATA_WIDTH-1:0]     wdf_data [WDF_DEPTH];
  logic [BYTES-1:0]          wdf_mask [WDF_DEPTH];
  logic [WQ_AW:0]            wq_wr, wq_rd;
  logic [DATA_WIDTH-1:0]     mem [MEM_DEPTH];
  logic [READ_LATENCY-1:0]   pipe_v;
  logic [DATA_WIDTH-1:0]     pipe_d [READ_LATENCY];
  logic                      rd_valid_q;
  logic [DATA_WIDTH-1:0]     rd_data_q;
  logic                      proto_err_q;

  logic                      stall_cmd, stall_wdf;
  logic                      cq_full, cq_empty, wq_full, wq_empty;
  logic                      cmd_rdy, wdf_rdy, cmd_fire, cmd_ok, bad_cmd, wdf_mismatch;
  logic                      cq_push, wq_push, exec_read, exec_write;
  logic [ENTRY_W-1:0]        head;
  logic                      head_is_read;
  logic [MEM_DEPTH_LOG2-1:0] head_idx, cmd_idx;
  logic [DATA_WIDTH-1:0]     wq_head_data;
  logic [BYTES-1:0]          wq_head_mask;
  logic                      unused_addr_bits;

`ifdef DDR3_UI_RANDOM_STALL_EN
  logic [15:0] lfsr;

  // Free-running LFSR that randomly withholds the two ready signals
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) lfsr <= 16'hACE1;
    else        lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  assign stall_cmd = (lfsr[1:0] == 2'b00);
  assign stall_wdf = (lfsr[3:2] == 2'b00);
`else
  assign stall_cmd = 1'b0;
  assign stall_wdf = 1'b0;
`endif

  // Address bits above the RAM index and the sub-burst offset alias away
  assign unused_addr_bits = ^{ui.app_addr[ADDR_WIDTH-1:MEM_DEPTH_LOG2+3], ui.app_addr[2:0]};
  assign cmd_idx = ui.app_addr[MEM_DEPTH_LOG2+2:3];

  assign cq_empty = (cq_wr == cq_rd);
  assign cq_full  = (cq_wr[CQ_AW] != cq_rd[CQ_AW]) && (cq_wr[CQ_AW-1:0] == cq_rd[CQ_AW-1:0]);
  assign wq_empty = (wq_wr == wq_rd);
  assign wq_full  = (wq_wr[WQ_AW] != wq_rd[WQ_AW]) && (wq_wr[WQ_AW-1:0] == wq_rd[WQ_AW-1:0]);

  assign cmd_rdy      = calib && !cq_full && !stall_cmd;
  assign wdf_rdy      = calib && !wq_full && !stall_wdf;
  assign cmd_fire     = ui.app_en && cmd_rdy;
  assign cmd_ok       = (ui.app_cmd == 3'b000) || (ui.app_cmd == 3'b001);
  assign cq_push      = cmd_fire && cmd_ok;
  assign bad_cmd      = cmd_fire && !cmd_ok;
  assign wq_push      = ui.app_wdf_wren && wdf_rdy;
  assign wdf_mismatch = (ui.app_wdf_wren != ui.app_wdf_end);

  assign head         = cmdq[cq_rd[CQ_AW-1:0]];
  assign head_is_read = head[ENTRY_W-1];
  assign head_idx     = head[MEM_DEPTH_LOG2-1:0];
  assign wq_head_data = wdf_data[wq_rd[WQ_AW-1:0]];
  assign wq_head_mask = wdf_mask[wq_rd[WQ_AW-1:0]];

  // A write head stalls until its data beat exists, blocking everything behind it
  assign exec_read  = !cq_empty && head_is_read;
  assign exec_write = !cq_empty && !head_is_read && !wq_empty;

  // Calibration delay counter, then init_calib_complete stays high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      calib_cnt <= '0;
      calib     <= 1'b0;
    end else if (!calib) begin
      if (calib_cnt == CAL_W'(CALIB_CYCLES - 1)) calib <= 1'b1;
      else                                       calib_cnt <= calib_cnt + 1'b1;
    end
  end

  // Queue and FIFO pointers; simultaneous push and pop keep occupancy unchanged
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cq_wr <= '0;
      cq_rd <= '0;
      wq_wr <= '0;
      wq_rd <= '0;
    end else begin
      if (cq_push)                  cq_wr <= cq_wr + 1'b1;
      if (exec_read || exec_write)  cq_rd <= cq_rd + 1'b1;
      if (wq_push)                  wq_wr <= wq_wr + 1'b1;
      if (exec_write)               wq_rd <= wq_rd + 1'b1;
    end
  end

  // Queue and FIFO storage needs no reset because the pointers gate it
  always_ff @(posedge clk) begin
    if (cq_push) cmdq[cq_wr[CQ_AW-1:0]] <= {ui.app_cmd[0], cmd_idx};
    if (wq_push) begin
      wdf_data[wq_wr[WQ_AW-1:0]] <= ui.app_wdf_data;
      wdf_mask[wq_wr[WQ_AW-1:0]] <= ui.app_wdf_mask;
    end
  end

  // Byte-masked RAM write; a set mask bit leaves that byte untouched
  always_ff @(posedge clk) begin
    if (exec_write) begin
      for (int b = 0; b < BYTES; b++) begin
        if (!wq_head_mask[b]) mem[head_idx][b*8 +: 8] <= wq_head_data[b*8 +: 8];
      end
    end
  end

  // Read data pipe contents; stage 0 captures the RAM word at execution
  always_ff @(posedge clk) begin
    if (exec_read) pipe_d[0] <= mem[head_idx];
    for (int i = 1; i < READ_LATENCY; i++) pipe_d[i] <= pipe_d[i-1];
  end

  // Read valid pipe and output registers; reset drops any in-flight reads
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_v     <= '0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= '0;
    end else begin
      pipe_v[0] <= exec_read;
      for (int i = 1; i < READ_LATENCY; i++) pipe_v[i] <= pipe_v[i-1];
      rd_valid_q <= pipe_v[READ_LATENCY-1];
      if (pipe_v[READ_LATENCY-1]) rd_data_q <= pipe_d[READ_LATENCY-1];
    end
  end

  // Sticky protocol error flag for unknown commands or wren/end disagreement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                        proto_err_q <= 1'b0;
    else if (bad_cmd || wdf_mismatch)  proto_err_q <= 1'b1;
  end

  assign ui.app_rdy             = cmd_rdy;
  assign ui.app_wdf_rdy         = wdf_rdy;
  assign ui.app_rd_data         = rd_data_q;
  assign ui.app_rd_data_valid   = rd_valid_q;
  assign ui.app_rd_data_end     = rd_valid_q;
  assign ui.init_calib_complete = calib;
  assign ui.proto_err           = proto_err_q;
endmodule
